// File: rtl/spi_controller.sv
// SPI mode-0 master: shifts a 16-bit {rw, addr, wdata} frame MSB first, keeps the
// last 8 cipo bits as rdata, and enforces an nCS-high gap before signalling done.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       cipo,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nCS,
  output logic       SCLK,
  output logic       copi
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t      state, state_nx;
  logic [7:0]  div_cnt, div_nx;
  logic [3:0]  bit_cnt, bit_nx;
  logic [15:0] frame, frame_nx;
  logic [7:0]  rx, rx_nx;
  logic [7:0]  rdata_nx;
  logic        ncs_nx, sclk_nx, copi_nx, busy_nx, done_nx;
  logic        div_last, gap_last;

  assign div_last = (div_cnt == 8'(CLK_DIV - 1));
  assign gap_last = (div_cnt == 8'(GAP_CYCLES - 1));

  // Every output is computed here one cycle ahead and registered below, so the
  // pins change exactly on the edge where the state changes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nx = state;
    div_nx   = div_cnt + 8'd1;
    bit_nx   = bit_cnt;
    frame_nx = frame;
    rx_nx    = rx;
    rdata_nx = rdata;
    ncs_nx   = nCS;
    sclk_nx  = SCLK;
    copi_nx  = copi;
    busy_nx  = busy;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        div_nx  = 8'd0;
        busy_nx = 1'b0;
        if (start) begin
          state_nx = SETUP;
          frame_nx = {rw, addr, wdata};
          bit_nx   = 4'd15;
          ncs_nx   = 1'b0;
          sclk_nx  = 1'b0;
          copi_nx  = rw;
          busy_nx  = 1'b1;
        end
      end
      SETUP, LOW: begin
        if (div_last) begin
          state_nx = HIGH;
          div_nx   = 8'd0;
          sclk_nx  = 1'b1;
          rx_nx    = {rx[6:0], cipo};
        end
      end
      HIGH: begin
        if (div_last) begin
          div_nx  = 8'd0;
          sclk_nx = 1'b0;
          if (bit_cnt == 4'd0) begin
            state_nx = HOLD;
          end else begin
            state_nx = LOW;
            bit_nx   = bit_cnt - 4'd1;
            copi_nx  = frame[bit_cnt - 4'd1];
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          state_nx = GAP;
          div_nx   = 8'd0;
          ncs_nx   = 1'b1;
          copi_nx  = 1'b0;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_nx = IDLE;
          div_nx   = 8'd0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          rdata_nx = rx;
        end
      end
      default: begin
        state_nx = IDLE;
        div_nx   = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 4'd0;
      frame   <= 16'd0;
      rx      <= 8'd0;
      rdata   <= 8'd0;
      nCS     <= 1'b1;
      SCLK    <= 1'b0;
      copi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      frame   <= frame_nx;
      rx      <= rx_nx;
      rdata   <= rdata_nx;
      nCS     <= ncs_nx;
      SCLK    <= sclk_nx;
      copi    <= copi_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench for spi_controller: records a per-cycle pin trace and judges it
// against frame-level timing rules (latency, nCS window, SCLK phases, bit order).
module tb_spi_controller;

  localparam int DF = 4;
  localparam int GF = 4;
  localparam int DS = 255;
  localparam int GS = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       cipo;
  logic       sel   = 1'b0;

  logic       start_f, start_s;
  logic       busy_f, done_f, ncs_f, sclk_f, copi_f;
  logic       busy_s, done_s, ncs_s, sclk_s, copi_s;
  logic [7:0] rdata_f, rdata_s;
  logic       busy_m, done_m, ncs_m, sclk_m, copi_m;
  logic [7:0] rdata_m;

  always #5 clk = ~clk;

  assign start_f = start & ~sel;
  assign start_s = start & sel;

  spi_controller #(.CLK_DIV(DF), .GAP_CYCLES(GF)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .rw(rw), .addr(addr), .wdata(wdata),
    .cipo(cipo), .busy(busy_f), .done(done_f), .rdata(rdata_f), .nCS(ncs_f),
    .SCLK(sclk_f), .copi(copi_f)
  );

  spi_controller #(.CLK_DIV(DS), .GAP_CYCLES(GS)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .rw(rw), .addr(addr), .wdata(wdata),
    .cipo(cipo), .busy(busy_s), .done(done_s), .rdata(rdata_s), .nCS(ncs_s),
    .SCLK(sclk_s), .copi(copi_s)
  );

  assign busy_m  = sel ? busy_s  : busy_f;
  assign done_m  = sel ? done_s  : done_f;
  assign ncs_m   = sel ? ncs_s   : ncs_f;
  assign sclk_m  = sel ? sclk_s  : sclk_f;
  assign copi_m  = sel ? copi_s  : copi_f;
  assign rdata_m = sel ? rdata_s : rdata_f;

  // Peripheral model: presents resp MSB first, advancing after each SCLK rise.
  logic [31:0] resp = '0;
  int          rise_cnt = 0;
  always @(posedge sclk_m) rise_cnt = rise_cnt + 1;
  assign cipo = (rise_cnt < 32) ? resp[31 - rise_cnt] : 1'b0;

  typedef struct packed {
    logic       ncs;
    logic       sclk;
    logic       copi;
    logic       done;
    logic       busy;
    logic [7:0] rdata;
  } smp_t;

  smp_t trace[$];
  bit   recording = 1'b0;

  // Entry i of the trace is clock cycle i+1 after the accepting edge.
  always @(posedge clk) begin
    #1;
    if (recording) trace.push_back({ncs_m, sclk_m, copi_m, done_m, busy_m, rdata_m});
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic analyze(input int n, input logic [15:0] f0, input logic [15:0] f1,
                         input logic [31:0] rsp, input int d, input int g);
    int          len, t_sz, busy_cnt, ncs_bad, sclk_bad, copi_bad, r, i, run;
    int          dn_idx[$];
    int          rises[$];
    logic [7:0]  rd_done[$];
    logic [31:0] bits, exp_bits;
    logic [15:0] fw;
    bit          exp_low;
    len = 33 * d + g + 1;
    t_sz = trace.size();
    busy_cnt = 0; ncs_bad = 0; sclk_bad = 0; copi_bad = 0; bits = '0;
    for (int k = 0; k < t_sz; k++) begin
      if (trace[k].done) begin
        dn_idx.push_back(k);
        rd_done.push_back(trace[k].rdata);
      end
      if (trace[k].busy) busy_cnt++;
      exp_low = 1'b0;
      for (int f = 0; f < n; f++)
        if (k >= f * len && k < f * len + 33 * d) exp_low = 1'b1;
      if (trace[k].ncs == exp_low) ncs_bad++;
      if (trace[k].ncs && (trace[k].copi || trace[k].sclk)) copi_bad++;
      if (trace[k].sclk && (k == 0 || !trace[k-1].sclk)) rises.push_back(k);
    end
    check("done_count", dn_idx.size(), n);
    for (int f = 0; f < n && f < dn_idx.size(); f++) begin
      check("latency", dn_idx[f] + 1 - f * len, len);
      fw = rsp[31 - 16 * f -: 16];
      check("rdata_at_done", rd_done[f], fw[7:0]);
    end
    check("busy_cycles", busy_cnt, n * (len - 1));
    check("ncs_window_errs", ncs_bad, 0);
    check("sclk_rises", rises.size(), 16 * n);
    for (int j = 0; j < rises.size(); j++) begin
      r = rises[j];
      bits = {bits[30:0], trace[r].copi};
      for (int t = r; t < r + d; t++)
        if (t >= t_sz || !trace[t].sclk) sclk_bad++;
      if (r + d < t_sz && trace[r + d].sclk) sclk_bad++;
      if (j % 16 == 0) begin
        if (r != (j / 16) * len + d) sclk_bad++;
      end else if (r - rises[j-1] != 2 * d) begin
        sclk_bad++;
      end
      for (int t = r - d; t < r + d; t++)
        if (t >= 0 && t < t_sz && trace[t].copi != trace[r].copi) copi_bad++;
    end
    exp_bits = (n == 2) ? {f0, f1} : {16'h0, f0};
    check("copi_frame_bits", bits, exp_bits);
    check("sclk_phase_errs", sclk_bad, 0);
    check("copi_stability_errs", copi_bad, 0);
    if (n == 2) begin
      // The idle done cycle adds one nCS-high cycle to the GAP phase.
      i = 0;
      while (i < t_sz && !trace[i].ncs) i++;
      run = 0;
      while (i < t_sz && trace[i].ncs) begin run++; i++; end
      check("gap_ncs_high", run, g + 1);
    end
  endtask

  task automatic run_frames(input int n, input logic [15:0] f0, input logic [15:0] f1,
                            input logic [31:0] rsp, input int d, input int g,
                            input bit disturb);
    int len, seen, c;
    len = 33 * d + g + 1;
    seen = 0;
    trace.delete();
    @(negedge clk);
    resp = rsp;
    rise_cnt = 0;
    {rw, addr, wdata} = f0;
    start = 1'b1;
    recording = 1'b1;
    @(negedge clk);
    if (n == 2) {rw, addr, wdata} = f1;
    else begin
      start = 1'b0;
      {rw, addr, wdata} = 16'($urandom);
    end
    c = 1;
    while (c < n * len + 40 && seen < n) begin
      @(negedge clk);
      if (disturb && (c == 20 || c == 60)) begin
        start = 1'b1;
        {rw, addr, wdata} = 16'($urandom);
      end else if (disturb && (c == 21 || c == 61)) begin
        start = 1'b0;
      end
      if (n == 2 && seen == 1 && !done_m) start = 1'b0;
      if (done_m) seen++;
      c++;
    end
    start = 1'b0;
    check("done_within_budget", seen, n);
    repeat (12) @(negedge clk);
    recording = 1'b0;
    analyze(n, f0, f1, rsp, d, g);
  endtask

  task automatic reset_mid_frame();
    int dones, highs;
    @(negedge clk);
    sel = 1'b0;
    resp = $urandom;
    rise_cnt = 0;
    {rw, addr, wdata} = 16'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400 && rise_cnt < 5; c++) @(negedge clk);
    check("reached_5th_rise", rise_cnt, 5);
    rst = 1'b1;
    #1;
    check("rst_ncs", ncs_f, 1'b1);
    check("rst_sclk", sclk_f, 1'b0);
    check("rst_copi", copi_f, 1'b0);
    check("rst_busy_done", {busy_f, done_f}, 2'b00);
    check("rst_rdata", rdata_f, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    dones = 0; highs = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_f) dones++;
      if (ncs_f) highs++;
    end
    check("no_done_after_abort", dones, 0);
    check("idle_after_abort", highs, 300);
  endtask

  initial begin
    logic [15:0] fa, fb;
    logic [31:0] rr;

    #2 rst = 1'b1;
    #10;
    check("reset_ncs", {ncs_f, ncs_s}, 2'b11);
    check("reset_sclk_copi", {sclk_f, copi_f, sclk_s, copi_s}, 4'b0000);
    check("reset_busy_done", {busy_f, done_f, busy_s, done_s}, 4'b0000);
    check("reset_rdata", {rdata_f, rdata_s}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Write 0x80 to register 0x04.
    run_frames(1, {1'b1, 7'h04, 8'h80}, 16'h0, $urandom, DF, GF, 1'b0);
    // Read of register 0x01 with the peripheral answering 0xA5.
    rr = {8'($urandom), 8'hA5, 16'($urandom)};
    run_frames(1, {1'b0, 7'h01, 8'($urandom)}, 16'h0, rr, DF, GF, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fa = 16'($urandom);
      run_frames(1, fa, 16'h0, $urandom, DF, GF, 1'b0);
    end

    // Back-to-back writes with start held high.
    run_frames(2, {1'b1, 7'h00, 8'hFF}, {1'b1, 7'h02, 8'h0F}, $urandom, DF, GF, 1'b0);
    fa = 16'($urandom);
    fb = 16'($urandom);
    run_frames(2, fa, fb, $urandom, DF, GF, 1'b0);

    // Start pulses with new inputs mid-frame must be ignored.
    run_frames(1, 16'($urandom), 16'h0, $urandom, DF, GF, 1'b1);

    reset_mid_frame();
    run_frames(1, {1'b1, 7'($urandom), 8'($urandom)}, 16'h0, $urandom, DF, GF, 1'b0);

    sel = 1'b1;
    run_frames(1, {1'b1, 7'($urandom), 8'($urandom)}, 16'h0, $urandom, DS, GS, 1'b0);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
